// File: rtl/pot_accumulator_pkg.sv
// Shared types and helpers for the power-of-two dot-product accumulator.
package pot_accumulator_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } acc_state_e;

    // Ceiling log2, evaluated at elaboration time for widths.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned rem;
        result = 0;
        rem    = (value > 0) ? value - 1 : 0;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pot_accumulator_signed_saturate.sv
// Clips a signed value into a narrower signed range and flags the clip.
module signed_saturate #(
    parameter int unsigned IN_WIDTH  = 12,
    parameter int unsigned OUT_WIDTH = 8
) (
    input  logic signed [IN_WIDTH-1:0]  value,
    output logic signed [OUT_WIDTH-1:0] value_sat,
    output logic                        overflow
);

    generate
        if (OUT_WIDTH >= IN_WIDTH) begin : g_pass
            // Output is wide enough for every input: sign-extend only.
            assign value_sat = OUT_WIDTH'(value);
            assign overflow  = 1'b0;
        end else begin : g_clip
            localparam logic signed [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
            localparam logic signed [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

            logic [IN_WIDTH-OUT_WIDTH:0] top_bits;
            logic                        fits;

            // Value fits when all bits above the output sign bit match it.
            assign top_bits  = value[IN_WIDTH-1:OUT_WIDTH-1];
            assign fits      = (&top_bits) | ~(|top_bits);
            assign overflow  = ~fits;
            assign value_sat = fits ? value[OUT_WIDTH-1:0]
                                    : (value[IN_WIDTH-1] ? SAT_MIN : SAT_MAX);
        end
    endgenerate

endmodule

// File: rtl/pot_accumulator.sv
// Accumulates VECTOR_LENGTH signed product terms and emits one saturated sum per vector.
module pot_accumulator
    import pot_accumulator_pkg::*;
#(
    parameter int unsigned PRODUCT_BIT_WIDTH = 8,
    parameter int unsigned VECTOR_LENGTH     = 16,
    parameter int unsigned OUTPUT_BIT_WIDTH  = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic signed [PRODUCT_BIT_WIDTH-1:0] in_product,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic signed [OUTPUT_BIT_WIDTH-1:0]  out_sum,
    output logic                                out_overflow
);

    localparam int unsigned ACC_BIT_WIDTH = PRODUCT_BIT_WIDTH + clog2(VECTOR_LENGTH);
    localparam int unsigned CNT_W         = clog2(VECTOR_LENGTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(VECTOR_LENGTH - 1);

    acc_state_e                        state_q, state_d;
    logic signed [ACC_BIT_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]                  cnt_q, cnt_d;
    logic signed [OUTPUT_BIT_WIDTH-1:0] out_sum_q, out_sum_d;
    logic                              out_ovf_q, out_ovf_d;

    logic signed [ACC_BIT_WIDTH-1:0]   sum_c;
    logic signed [OUTPUT_BIT_WIDTH-1:0] sat_c;
    logic                              ovf_c;

    // Accumulator width is sized so this addition never wraps.
    assign sum_c = acc_q + ACC_BIT_WIDTH'(in_product);

    signed_saturate #(
        .IN_WIDTH (ACC_BIT_WIDTH),
        .OUT_WIDTH(OUTPUT_BIT_WIDTH)
    ) u_sat (
        .value    (sum_c),
        .value_sat(sat_c),
        .overflow (ovf_c)
    );

    // Next-state: clear beats every handshake; last term latches the result.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        out_sum_d = out_sum_q;
        out_ovf_d = out_ovf_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (in_valid) begin
                        if (cnt_q == CNT_LAST) begin
                            out_sum_d = sat_c;
                            out_ovf_d = ovf_c;
                            acc_d     = '0;
                            cnt_d     = '0;
                            state_d   = HOLD;
                        end else begin
                            acc_d = sum_c;
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ACCUM;
            acc_q     <= '0;
            cnt_q     <= '0;
            out_sum_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            out_sum_q <= out_sum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

    assign in_ready     = (state_q == ACCUM);
    assign out_valid    = (state_q == HOLD);
    assign out_sum      = out_sum_q;
    assign out_overflow = out_ovf_q;

endmodule

// File: tb/tb_pot_accumulator.sv
// Self-checking bench: vector table plus hand-built stall, clear, reset and gap sequences.
module tb_pot_accumulator;

    logic              clk = 1'b0;
    logic              rst;
    logic              clear;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] in_product;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] out_sum;
    logic              out_overflow;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic signed [7:0] sum;
        logic              ovf;
    } exp_t;

    typedef struct {
        logic signed [7:0] a;
        logic signed [7:0] b;
        logic signed [7:0] c;
        logic signed [7:0] d;
        logic signed [7:0] sum;
        logic              ovf;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[10];

    pot_accumulator #(
        .PRODUCT_BIT_WIDTH(8),
        .VECTOR_LENGTH    (4),
        .OUTPUT_BIT_WIDTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .clear       (clear),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_product  (in_product),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Scoreboard: pop and compare each accepted result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_sum", longint'(out_sum), longint'(e.sum));
                check("out_overflow", longint'(out_overflow), longint'(e.ovf));
            end
        end
    end

    task automatic send_term(input logic signed [7:0] v, input int max_gap);
        int  gap;
        bit  accepted;
        gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (gap) begin
            in_valid   = 1'b0;
            in_product = 8'sd55;
            @(posedge clk); #1;
        end
        in_valid   = 1'b1;
        in_product = v;
        accepted   = 1'b0;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk); #1;
        end
        in_valid   = 1'b0;
        in_product = 8'sd0;
        if (!accepted) check("send_timeout", 0, 1);
    endtask

    task automatic send_vec(input logic signed [7:0] a, input logic signed [7:0] b,
                            input logic signed [7:0] c, input logic signed [7:0] d,
                            input bit push, input logic signed [7:0] s, input logic o,
                            input int max_gap);
        exp_t e;
        send_term(a, max_gap);
        send_term(b, max_gap);
        send_term(c, max_gap);
        if (push) begin
            e.sum = s;
            e.ovf = o;
            exp_q.push_back(e);
        end
        send_term(d, max_gap);
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", longint'(exp_q.size()), 0);
            exp_q.delete();
        end
    endtask

    task automatic set_vec(input int i, input logic signed [7:0] a, input logic signed [7:0] b,
                           input logic signed [7:0] c, input logic signed [7:0] d,
                           input logic signed [7:0] s, input logic o);
        tbl[i].a = a; tbl[i].b = b; tbl[i].c = c; tbl[i].d = d;
        tbl[i].sum = s; tbl[i].ovf = o;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        set_vec(0,   8'sd10,  -8'sd3,    8'sd7,    8'sd1,    8'sd15,  1'b0);
        set_vec(1,   8'sd127,  8'sd127,  8'sd127,  8'sd127,  8'sd127, 1'b1);
        set_vec(2,  -8'sd128, -8'sd128, -8'sd128, -8'sd128, -8'sd128, 1'b1);
        set_vec(3,   8'sd1,    8'sd1,    8'sd1,    8'sd1,    8'sd4,   1'b0);
        set_vec(4,   8'sd50,   8'sd50,   8'sd50,  -8'sd100,  8'sd50,  1'b0);
        set_vec(5,   8'sd100,  8'sd100, -8'sd128, -8'sd100, -8'sd28,  1'b0);
        set_vec(6,   8'sd64,   8'sd64,  -8'sd1,    8'sd0,    8'sd127, 1'b0);
        set_vec(7,   8'sd64,   8'sd64,   8'sd0,    8'sd0,    8'sd127, 1'b1);
        set_vec(8,  -8'sd64,  -8'sd64,   8'sd0,    8'sd0,   -8'sd128, 1'b0);
        set_vec(9,  -8'sd64,  -8'sd64,  -8'sd1,    8'sd0,   -8'sd128, 1'b1);

        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_product = 8'sd0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_sum", longint'(out_sum), 0);
        check("rst_out_overflow", longint'(out_overflow), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", longint'(in_ready), 1);
        @(posedge clk); #1;

        // Back-to-back table vectors; result must appear right after the 4th term.
        for (int i = 0; i < 10; i++) begin
            send_vec(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, 1'b1, tbl[i].sum, tbl[i].ovf, 0);
            check("latency_out_valid", longint'(out_valid), 1);
            check("hold_in_ready", longint'(in_ready), 0);
        end
        drain();

        // Stall in HOLD with in_valid asserted: nothing absorbed, result stable.
        out_ready = 1'b0;
        send_vec(8'sd5, 8'sd5, 8'sd5, 8'sd5, 1'b1, 8'sd20, 1'b0, 0);
        in_valid   = 1'b1;
        in_product = 8'sd99;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", longint'(out_valid), 1);
            check("stall_in_ready", longint'(in_ready), 0);
            check("stall_out_sum", longint'(out_sum), 20);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();
        send_vec(8'sd1, 8'sd1, 8'sd1, 8'sd1, 1'b1, 8'sd4, 1'b0, 0);
        drain();

        // Clear mid-vector discards partial sum and the concurrent term.
        send_term(8'sd50, 0);
        send_term(8'sd50, 0);
        clear = 1'b1; in_valid = 1'b1; in_product = 8'sd77;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        send_vec(8'sd1, 8'sd2, 8'sd3, 8'sd4, 1'b1, 8'sd10, 1'b0, 0);
        drain();

        // Clear in HOLD drops the pending result.
        out_ready = 1'b0;
        send_vec(8'sd9, 8'sd9, 8'sd9, 8'sd9, 1'b0, 8'sd0, 1'b0, 0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        check("clear_hold_out_valid", longint'(out_valid), 0);
        check("clear_hold_in_ready", longint'(in_ready), 1);
        out_ready = 1'b1;

        // Random input gaps must not disturb the term count.
        send_vec(-8'sd1, -8'sd1, -8'sd1, -8'sd1, 1'b1, -8'sd4, 1'b0, 3);
        drain();

        // Asynchronous reset mid-vector after a saturated result is on the outputs.
        send_vec(8'sd127, 8'sd127, 8'sd127, 8'sd127, 1'b1, 8'sd127, 1'b1, 0);
        drain();
        send_term(8'sd9, 0);
        send_term(8'sd9, 0);
        send_term(8'sd9, 0);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_sum", longint'(out_sum), 0);
        check("async_rst_out_overflow", longint'(out_overflow), 0);
        check("async_rst_out_valid", longint'(out_valid), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", longint'(in_ready), 1);
        check("post_rst_out_valid", longint'(out_valid), 0);
        send_vec(8'sd2, 8'sd2, 8'sd2, 8'sd2, 1'b1, 8'sd8, 1'b0, 0);
        drain();

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pot_accumulator.md
POT_ACCUMULATOR -- requirements
Module: pot_accumulator

Interface
REQ-001 SHALL have parameter PRODUCT_BIT_WIDTH, default 8: width of each signed power-of-two product term from the upstream shift stage.
REQ-002 SHALL have parameter VECTOR_LENGTH, default 16: terms per dot product, at least 2.
REQ-003 SHALL have parameter OUTPUT_BIT_WIDTH, default 16: width of the saturated result, at most ACC_BIT_WIDTH.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port clear, input, 1 bit: synchronous abort of the current vector.
REQ-008 SHALL have port in_valid, input, 1 bit: in_product is valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a term.
REQ-010 SHALL have port in_product, input, signed PRODUCT_BIT_WIDTH: product term.
REQ-011 SHALL have port out_valid, output, 1 bit: result is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-013 SHALL have port out_sum, output, signed OUTPUT_BIT_WIDTH: saturated dot-product sum.
REQ-014 SHALL have port out_overflow, output, 1 bit: out_sum was clipped.

Function
REQ-015 SHALL define ACC_BIT_WIDTH = PRODUCT_BIT_WIDTH + clog2(VECTOR_LENGTH), so the accumulator cannot wrap internally.
REQ-016 SHALL implement two FSM states: ACCUM, where in_ready=1 and out_valid=0, and HOLD, where in_ready=0 and out_valid=1.
REQ-017 SHALL define an input handshake as in_valid & in_ready at a rising edge; on a handshake, acc <= acc + sign-extended in_product and the term counter increments.
REQ-018 SHALL, on the handshake of term VECTOR_LENGTH, register out_sum = sat(acc + in_product), register out_overflow, and enter HOLD, so out_valid rises the cycle after the last term is accepted.
REQ-019 SHALL leave acc and the counter unchanged in cycles with no input handshake; gaps in in_valid are allowed.
REQ-020 SHALL, in HOLD, hold out_sum and out_overflow stable until out_valid & out_ready; on that edge it enters ACCUM with acc=0 and counter=0.
REQ-021 SHALL compute sat() as follows: above 2^(OUTPUT_BIT_WIDTH-1)-1 gives max with out_overflow=1; below -2^(OUTPUT_BIT_WIDTH-1) gives min with out_overflow=1; otherwise the value is passed through with out_overflow=0.
REQ-022 SHALL give clear priority over every handshake: the next state is ACCUM with acc=0 and counter=0, the in_product of that cycle is discarded, and out_valid drops the next cycle (a pending result is lost).
REQ-023 SHALL wrap the term counter from VECTOR_LENGTH-1 to 0 when the final term is accepted.
REQ-024 SHALL process back-to-back vectors with exactly one non-accepting cycle per vector (the HOLD cycle), provided out_ready is high.

Reset
REQ-025 SHALL, while rst=1, immediately force state=ACCUM, acc=0, counter=0, out_sum=0, out_overflow=0, and out_valid=0; in_ready is 1 after release.
REQ-026 SHALL abandon a vector that is in progress when reset asserts, with no partial result emitted.

Structure
REQ-027 SHALL place the FSM state encoding (ACCUM, HOLD) and the clog2 helper in the shared package.
REQ-028 SHALL place the saturation logic in sub-module signed_saturate, with parameters IN_WIDTH and OUT_WIDTH, input value, and outputs value_sat and overflow.
REQ-029 SHALL keep in_product the only datapath input, with no re-multiplication inside this block.

Verification (PRODUCT_BIT_WIDTH=8, VECTOR_LENGTH=4, OUTPUT_BIT_WIDTH=8)
REQ-030 SHALL be verified by: terms 10, -3, 7, 1 back-to-back -> out_valid one cycle after the 4th term, out_sum=15, out_overflow=0.
REQ-031 SHALL be verified by: four terms of 127 -> out_sum=127 with out_overflow=1; then four terms of -128 -> out_sum=-128 with out_overflow=1.
REQ-032 SHALL be verified by: out_ready low for 5 cycles in HOLD while in_valid=1 -> out_sum stable, in_ready=0, no term absorbed; the next vector 1, 1, 1, 1 -> 4.
REQ-033 SHALL be verified by: two terms 50, 50, then clear, then 1, 2, 3, 4 -> out_sum=10.
REQ-034 SHALL be verified by: rst pulsed between edges after 3 terms -> outputs 0 immediately, no out_valid; the next vector 2, 2, 2, 2 -> 8.
REQ-035 SHALL be verified by: in_valid toggled randomly with terms -1 ×4 -> out_sum=-4, with the count unaffected by the gaps.
